in_filter4_frame_config: RTL and testbench



---
 rtl/in_filter4_frame_config_if.sv | 12 +
 rtl/in_filter4_frame_config.sv | 99 +++++++++
 tb/tb_in_filter4_frame_config.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/in_filter4_frame_config_if.sv
// Pad-side and fabric-side signals of the four-channel input conditioner,
// plus the frame configuration word that sets channel modes and the filter threshold.
interface in_filter4_frame_config_if #(
  parameter int NoConfigBits = 12
);
  logic                    I0, I1, I2, I3;
  logic                    O0, O1, O2, O3;
  logic [NoConfigBits-1:0] ConfigBits;

  modport master (output I0, I1, I2, I3, ConfigBits, input  O0, O1, O2, O3);
  modport slave  (input  I0, I1, I2, I3, ConfigBits, output O0, O1, O2, O3);
endinterface

// File: rtl/in_filter4_frame_config.sv
// Four-channel pad input conditioner: synchroniser, stability filter, and level/pulse/toggle output.
// Optional macro IN_FILTER_SYNC3_EN adds a third synchroniser stage per channel.
module in_filter4_chan #(
  parameter int FILTER_W = 4
) (
  input  logic                UserCLK,
  input  logic                RESET,
  input  logic                padIn,
  input  logic [1:0]          mode,
  input  logic [FILTER_W-1:0] thresh,
  output logic                chanOut
);
  logic                s1, s2, src, f, p, t, hit, pNext;
  logic [FILTER_W-1:0] cnt;

  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= padIn;
      s2 <= s1;
    end
  end

`ifdef IN_FILTER_SYNC3_EN
  logic s3;
  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) s3 <= 1'b0;
    else       s3 <= s2;
  end
  assign src = s3;
`else
  assign src = s2;
`endif

  // Compared with equality so a threshold lowered below cnt lets cnt wrap once to 0.
  assign hit   = (src != f) && (cnt == thresh);
  assign pNext = hit & src;

  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) begin
      f   <= 1'b0;
      cnt <= '0;
      p   <= 1'b0;
      t   <= 1'b0;
    end else begin
      p <= pNext;
      t <= t ^ pNext;
      if (src == f) begin
        cnt <= '0;
      end else if (hit) begin
        f   <= src;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    chanOut = src;
    case (mode)
      2'b00:   chanOut = src;
      2'b01:   chanOut = f;
      2'b10:   chanOut = p;
      default: chanOut = t;
    endcase
  end
endmodule

module in_filter4_frame_config #(
  parameter int NoConfigBits = 12,
  parameter int FILTER_W     = 4
) (
  input logic                         UserCLK,
  input logic                         RESET,
  in_filter4_frame_config_if.slave    bus
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]      padIn, chanOut;
  logic [FILTER_W-1:0]       thresh;

  assign padIn  = {bus.I3, bus.I2, bus.I1, bus.I0};
  assign thresh = bus.ConfigBits[NoConfigBits-1 -: FILTER_W];
  assign {bus.O3, bus.O2, bus.O1, bus.O0} = chanOut;

  for (genvar c = 0; c < NUM_LANES; c++) begin : gLane
    in_filter4_chan #(.FILTER_W(FILTER_W)) uChan (
      .UserCLK (UserCLK),
      .RESET   (RESET),
      .padIn   (padIn[c]),
      .mode    (bus.ConfigBits[2*c+1 -: 2]),
      .thresh  (thresh),
      .chanOut (chanOut[c])
    );
  end
endmodule

// File: tb/tb_in_filter4_frame_config.sv
// Directed bench for in_filter4_frame_config (default two-stage synchroniser build).
module tb_in_filter4_frame_config;
  logic UserCLK = 1'b0;
  logic RESET   = 1'b1;
  int   errCnt  = 0;
  int   chkCnt  = 0;

  in_filter4_frame_config_if #(.NoConfigBits(12)) bus ();

  in_filter4_frame_config #(.NoConfigBits(12), .FILTER_W(4)) dut (
    .UserCLK (UserCLK),
    .RESET   (RESET),
    .bus     (bus)
  );

  always #5 UserCLK = ~UserCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {bus.O3, bus.O2, bus.O1, bus.O0};
  endfunction

  task automatic setIn(input logic [3:0] v);
    {bus.I3, bus.I2, bus.I1, bus.I0} = v;
  endtask

  // modes packed {m3,m2,m1,m0}
  task automatic cfg(input logic [7:0] modes, input logic [3:0] th);
    bus.ConfigBits = {th, modes};
  endtask

  task automatic doReset();
    setIn(4'h0);
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  logic [11:0] pulseSeq;
  logic [23:0] togSeq, togExp;

  initial begin
    setIn(4'hF);
    cfg({2'b11, 2'b10, 2'b01, 2'b00}, 4'd0);
    // Reset held with all pads high and every mode present
    step(); step(); step();
    chk("rst_hold", outs(), 4'h0);
    RESET = 1'b0;
    step();
    chk("rst_edge_n", outs(), 4'b0000);
    step();
    chk("rst_edge_n1", outs(), 4'b0001);
    step();
    chk("rst_edge_n2", outs(), 4'b1111);
    step();
    chk("rst_edge_n3", outs(), 4'b1011);

    // Level, T=3: short glitch rejected, steady high passes after n+5
    doReset();
    cfg(8'b00_00_00_01, 4'd3);
    setIn(4'h1);
    step(); step();
    setIn(4'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("lvl_glitch", bus.O0, 1'b0);
    end
    setIn(4'h1);
    for (int k = 0; k < 5; k++) step();
    chk("lvl_n4", bus.O0, 1'b0);
    step();
    chk("lvl_n5", bus.O0, 1'b1);
    for (int k = 0; k < 4; k++) step();
    chk("lvl_hold", bus.O0, 1'b1);

    // Pulse, T=0: one pulse after n+2, none on the falling edge
    doReset();
    cfg(8'b00_00_10_00, 4'd0);
    setIn(4'h2);
    for (int k = 0; k < 12; k++) begin
      if (k == 4) setIn(4'h0);
      step();
      pulseSeq[k] = bus.O1;
    end
    chk("pulse_seq", {20'd0, pulseSeq}, 32'h0000_0004);

    // Toggle, T=1: three rising edges, flips after n+3 of each
    doReset();
    cfg(8'b00_11_00_00, 4'd1);
    for (int k = 0; k < 24; k++) begin
      setIn(((k % 8) < 4) ? 4'h4 : 4'h0);
      step();
      togSeq[k] = bus.O2;
      togExp[k] = (k >= 3) ^ (k >= 11) ^ (k >= 19);
    end
    chk("toggle_seq", {8'd0, togSeq}, {8'd0, togExp});

    // Async reset mid-count (T=15, cnt=7 on channel 3), then full recount
    doReset();
    cfg(8'b01_00_00_00, 4'd15);
    setIn(4'h9);
    for (int k = 0; k < 9; k++) step();
    chk("mid_pre", outs(), 4'b0001);
    #3 RESET = 1'b1;
    #1 chk("mid_async", outs(), 4'b0000);
    step();
    RESET = 1'b0;
    for (int k = 0; k < 17; k++) begin
      step();
      chk("mid_recount", bus.O3, 1'b0);
    end
    step();
    chk("mid_rise", bus.O3, 1'b1);

    // Mode switch on channel 0: toggle value survives, no spurious pulse
    doReset();
    cfg(8'b00_00_00_11, 4'd1);
    setIn(4'h1);
    for (int k = 0; k < 6; k++) step();
    chk("sw_tog1", bus.O0, 1'b1);
    cfg(8'b00_00_00_00, 4'd1);
    step();
    chk("sw_bypass", bus.O0, 1'b1);
    cfg(8'b00_00_00_10, 4'd1);
    step();
    chk("sw_pulse", bus.O0, 1'b0);
    cfg(8'b00_00_00_11, 4'd1);
    step();
    chk("sw_tog_back", bus.O0, 1'b1);
    step(); step();
    chk("sw_tog_hold", bus.O0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
